// File: rtl/pc_seq_pkg.sv
// Shared encodings for the PC sequencer: next-PC command opcodes and the FSM state type.
package pc_seq_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_INC  = 3'd0;
    localparam logic [OP_W-1:0] OP_BR   = 3'd1;
    localparam logic [OP_W-1:0] OP_JMP  = 3'd2;
    localparam logic [OP_W-1:0] OP_CALL = 3'd3;
    localparam logic [OP_W-1:0] OP_RET  = 3'd4;
    localparam logic [OP_W-1:0] OP_HALT = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT_CMD,
        HALTED
    } seq_state_e;

endpackage

// File: rtl/pc_seq_ras.sv
// Circular return-address stack: a push when full silently overwrites the oldest entry.
module ras_stack #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] top_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d, top_ptr;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign top_ptr = ptr_q - PTR_W'(1);
    assign top_o   = mem_q[top_ptr];
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);

    // DEPTH is a power of two, so the write pointer wraps for free and the count saturates.
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push_i) begin
            ptr_d = ptr_q + PTR_W'(1);
            if (!full_o) cnt_d = cnt_q + CNT_W'(1);
        end else if (pop_i && !empty_o) begin
            ptr_d = top_ptr;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[ptr_q] <= data_i;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch handshake, next-PC commands and a return-address stack.
// Define PC_SEQ_RAS_TRAP_EN to halt with a sticky ras_err on RAS overflow/underflow.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              PC_W      = 16,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              PC_INC    = 2,
    parameter int              RAS_DEPTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    output logic            instr_valid,
    input  logic            cmd_valid,
    input  logic [OP_W-1:0] cmd_op,
    input  logic            cmd_cond,
    input  logic [PC_W-1:0] cmd_target,
    output logic            cmd_ready,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic            ras_err
);

    localparam logic [PC_W-1:0] INC_V = PC_W'(PC_INC);

    seq_state_e      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, inc_pc, ras_top;
    logic            valid_q, valid_d;
    logic            push, pop, ras_full, ras_empty, accept, trap;

    assign inc_pc = pc_q + INC_V;
    assign accept = (state_q == WAIT_CMD) && cmd_valid;

`ifdef PC_SEQ_RAS_TRAP_EN
    logic ras_err_q;

    assign trap    = accept && (((cmd_op == OP_CALL) && ras_full) || ((cmd_op == OP_RET) && ras_empty));
    assign ras_err = ras_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ras_err_q <= 1'b0;
        else        ras_err_q <= ras_err_q | trap;
    end
`else
    assign trap    = 1'b0;
    assign ras_err = 1'b0;
`endif

    // A trapped command leaves pc and the RAS untouched and parks the sequencer.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    state_d = WAIT_CMD;
                    valid_d = 1'b1;
                end
            end
            WAIT_CMD: begin
                if (accept) begin
                    state_d = FETCH;
                    if (trap) begin
                        state_d = HALTED;
                    end else begin
                        case (cmd_op)
                            OP_BR:   pc_d = cmd_cond ? (pc_q + cmd_target) : inc_pc;
                            OP_JMP:  pc_d = cmd_target;
                            OP_CALL: begin
                                push = 1'b1;
                                pc_d = cmd_target;
                            end
                            OP_RET: begin
                                pop  = 1'b1;
                                pc_d = ras_empty ? RESET_PC : ras_top;
                            end
                            OP_HALT: state_d = HALTED;
                            default: pc_d = inc_pc;
                        endcase
                    end
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    ras_stack #(
        .DEPTH(RAS_DEPTH),
        .W    (PC_W)
    ) u_ras (
        .clk_i  (clk),
        .rst_ni (reset),
        .push_i (push),
        .pop_i  (pop),
        .data_i (inc_pc),
        .top_o  (ras_top),
        .full_o (ras_full),
        .empty_o(ras_empty)
    );

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign cmd_ready   = (state_q == WAIT_CMD);
    assign pc          = pc_q;
    assign halted      = (state_q == HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a queue-based PC/RAS model predicts every fetch address.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    localparam int          DEPTH  = 8;
    localparam logic [15:0] RST_PC = 16'h0000;
    localparam logic [15:0] INC    = 16'd2;
`ifdef PC_SEQ_RAS_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk, reset;
    logic        imem_req, imem_ack, instr_valid;
    logic [15:0] imem_addr, pc, cmd_target;
    logic        cmd_valid, cmd_cond, cmd_ready, halted, ras_err;
    logic [2:0]  cmd_op;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] expQ[$];
    logic [15:0] mRas[$];
    logic [15:0] mPc;
    bit          mHalted, mRasErr;

    pc_sequencer #(
        .PC_W(16), .RESET_PC(16'h0000), .PC_INC(2), .RAS_DEPTH(8)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .instr_valid(instr_valid),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_cond(cmd_cond),
        .cmd_target(cmd_target), .cmd_ready(cmd_ready),
        .pc(pc), .halted(halted), .ras_err(ras_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reportTimeout(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Reference model: the RAS is a plain queue trimmed from the front when it outgrows DEPTH.
    task automatic modelStep(input logic [2:0] op, input logic cond, input logic [15:0] tgt);
        case (op)
            OP_BR:   mPc = cond ? mPc + tgt : mPc + INC;
            OP_JMP:  mPc = tgt;
            OP_CALL: begin
                if (TRAP && mRas.size() == DEPTH) begin
                    mHalted = 1'b1;
                    mRasErr = 1'b1;
                end else begin
                    mRas.push_back(mPc + INC);
                    if (mRas.size() > DEPTH) mRas.delete(0);
                    mPc = tgt;
                end
            end
            OP_RET: begin
                if (mRas.size() == 0) begin
                    if (TRAP) begin
                        mHalted = 1'b1;
                        mRasErr = 1'b1;
                    end else begin
                        mPc = RST_PC;
                    end
                end else begin
                    mPc = mRas.pop_back();
                end
            end
            OP_HALT: mHalted = 1'b1;
            default: mPc = mPc + INC;
        endcase
    endtask

    task automatic applyReset();
        reset     = 1'b0;
        imem_ack  = 1'b0;
        cmd_valid = 1'b0;
        expQ.delete();
        mRas.delete();
        mPc     = RST_PC;
        mHalted = 1'b0;
        mRasErr = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rstReq", imem_req, 0);
        checkOutput("rstValid", instr_valid, 0);
        checkOutput("rstReady", cmd_ready, 0);
        checkOutput("rstHalted", halted, 0);
        checkOutput("rstRasErr", ras_err, 0);
        checkOutput("rstPc", pc, RST_PC);
        reset = 1'b1;
        #1 checkOutput("idleReq", imem_req, 0);
        @(negedge clk);
        checkOutput("fetchStart", imem_req, 1);
    endtask

    // One full instruction: wait for the fetch, ack it, then hand over one command.
    task automatic applyStimulus(input logic [2:0] op, input logic cond, input logic [15:0] tgt,
                                 input int ackWait, input int cmdWait);
        int n;
        n = 0;
        while (!imem_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req) begin
            reportTimeout("fetchTimeout");
            return;
        end
        checkOutput("fetchAddr", imem_addr, mPc);
        expQ.push_back(mPc);
        repeat (ackWait) @(negedge clk);
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            reportTimeout("readyTimeout");
            return;
        end
        repeat (cmdWait) @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_cond   = cond;
        cmd_target = tgt;
        @(negedge clk);
        cmd_valid  = 1'b0;
        cmd_op     = 3'($urandom_range(0, 7));
        cmd_target = 16'($urandom);
        modelStep(op, cond, tgt);
        if (mHalted) begin
            checkOutput("haltedFlag", halted, 1);
            checkOutput("haltedReady", cmd_ready, 0);
            checkOutput("haltedReq", imem_req, 0);
            checkOutput("haltedPc", pc, mPc);
            checkOutput("haltedRasErr", ras_err, mRasErr);
        end
    endtask

    // Monitor: every instr_valid pulse must match exactly one outstanding fetch.
    always @(negedge clk) begin
        if (reset && instr_valid) begin
            compared++;
            if (expQ.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL spuriousInstrValid: got pulse at addr %h expected none", imem_addr);
            end else begin
                logic [15:0] e;
                e = expQ.pop_front();
                if (imem_addr !== e) begin
                    mismatched++;
                    $display("[TB] FAIL instrAddr: got %h expected %h", imem_addr, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [2:0] op;
        cmd_op = OP_INC; cmd_cond = 1'b0; cmd_target = '0;
        applyReset();

        repeat (3) applyStimulus(OP_INC, 1'b0, 16'h0, 2, 0);
        applyStimulus(OP_JMP, 1'b0, 16'h0010, 0, 0);
        applyStimulus(OP_BR,  1'b1, 16'hFFFC, 1, 0);
        applyStimulus(OP_JMP, 1'b0, 16'h0010, 0, 1);
        applyStimulus(OP_BR,  1'b0, 16'hFFFC, 0, 0);
        applyStimulus(OP_JMP, 1'b0, 16'hFFFE, 0, 0);
        applyStimulus(OP_INC, 1'b0, 16'h0, 0, 0);
        applyStimulus(OP_JMP, 1'b0, 16'h0020, 0, 0);
        applyStimulus(OP_CALL, 1'b0, 16'h0100, 1, 0);
        applyStimulus(OP_CALL, 1'b0, 16'h0200, 0, 0);
        applyStimulus(OP_RET,  1'b0, 16'h0, 0, 0);
        applyStimulus(OP_RET,  1'b0, 16'h0, 0, 0);
        applyStimulus(OP_INC,  1'b0, 16'h0, 0, 0);

        applyReset();
        for (int i = 0; i < 9; i++) applyStimulus(OP_CALL, 1'b0, 16'h1000 + 16'(i * 16), 0, 0);
`ifdef PC_SEQ_RAS_TRAP_EN
        checkOutput("trapPcHold", pc, 16'h1070);
        checkOutput("trapRasErr", ras_err, 1);
`else
        for (int i = 0; i < 9; i++) applyStimulus(OP_RET, 1'b0, 16'h0, 0, 0);
        applyStimulus(OP_INC, 1'b0, 16'h0, 0, 0);
        checkOutput("emptyRetWrapPc", pc, 16'h0002);
        checkOutput("rasErrTiedLow", ras_err, 0);
`endif

        applyReset();
        for (int i = 0; i < 300; i++) begin
            op = 3'($urandom_range(0, 7));
            if (op == OP_HALT) op = OP_JMP;
            if (TRAP && ((op == OP_CALL && mRas.size() == DEPTH) || (op == OP_RET && mRas.size() == 0)))
                op = OP_INC;
            applyStimulus(op, 1'($urandom_range(0, 1)), 16'($urandom),
                          $urandom_range(0, 3), $urandom_range(0, 2));
        end

        applyStimulus(OP_HALT, 1'b0, 16'h0, 0, 0);
        repeat (4) begin
            imem_ack   = 1'b1;
            cmd_valid  = 1'b1;
            cmd_op     = OP_JMP;
            cmd_target = 16'h5555;
            @(negedge clk);
        end
        imem_ack  = 1'b0;
        cmd_valid = 1'b0;
        checkOutput("haltStays", halted, 1);
        checkOutput("haltPcFrozen", pc, mPc);
        checkOutput("haltNoReq", imem_req, 0);
        checkOutput("haltNoReady", cmd_ready, 0);

        applyReset();
        applyStimulus(OP_INC, 1'b0, 16'h0, 0, 0);
        applyStimulus(OP_JMP, 1'b0, 16'h0400, 0, 0);
        checkOutput("preResetReq", imem_req, 1);
        #2 reset = 1'b0;
        #1;
        checkOutput("midResetReq", imem_req, 0);
        checkOutput("midResetPc", pc, RST_PC);
        @(negedge clk);
        applyReset();
        applyStimulus(OP_INC, 1'b0, 16'h0, 0, 0);
        applyStimulus(OP_INC, 1'b0, 16'h0, 1, 0);

        @(negedge clk);
        checkOutput("pendingFetches", expQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
